// File: rtl/fetch_stage_pkg.sv
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP             = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_ADDR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MSTALL = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_e;

  function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            i_hold;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_halt;
  logic [XLEN-1:0] o_imem_raddr;
  logic            o_imem_ren;
  logic [XLEN-1:0] i_imem_rdata;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_nxt_pc;
  logic            o_vld;
  logic            o_misalign;
  logic            o_halted;

  modport master (
    input  i_hold, i_redirect, i_redirect_pc, i_halt, i_imem_rdata,
    output o_imem_raddr, o_imem_ren, o_inst, o_pc, o_nxt_pc,
           o_vld, o_misalign, o_halted
  );

  modport slave (
    output i_hold, i_redirect, i_redirect_pc, i_halt, i_imem_rdata,
    input  o_imem_raddr, o_imem_ren, o_inst, o_pc, o_nxt_pc,
           o_vld, o_misalign, o_halted
  );

endinterface

// File: rtl/fetch_stage_pc_gen.sv
module pc_gen
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic            rst,
  input  fetch_state_e    state,
  input  logic            halt,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hold,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (rst) begin
      pc_nxt = RESET_ADDR;
    end else if (state == ST_HALT || halt) begin
      pc_nxt = pc;
    end else if (redirect) begin
      pc_nxt = redirect_pc;
    end else if (hold) begin
      pc_nxt = pc;
    end else if (state == ST_RUN && pc_aligned(pc)) begin
      pc_nxt = pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_stage_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] nxt_pc_q, nxt_pc_d;
  logic            vld_q, vld_d;
  logic            mis_q, mis_d;
  logic            halted_q, halted_d;

  pc_gen #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_gen (
    .rst         (i_rst),
    .state       (state_q),
    .halt        (bus.i_halt),
    .redirect    (bus.i_redirect),
    .redirect_pc (bus.i_redirect_pc),
    .hold        (bus.i_hold),
    .pc          (pc_q),
    .pc_nxt      (pc_d)
  );

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    id_pc_d  = id_pc_q;
    nxt_pc_d = nxt_pc_q;
    vld_d    = vld_q;
    mis_d    = mis_q;
    halted_d = halted_q;
    unique case (state_q)
      ST_RUN, ST_MSTALL: begin
        if (bus.i_halt) begin
          state_d  = ST_HALT;
          vld_d    = 1'b0;
          mis_d    = 1'b0;
          inst_d   = NOP;
          halted_d = 1'b1;
        end else if (bus.i_redirect) begin
          // Flushed entry is invalid, so any pending misalign flag is dropped too.
          state_d = ST_RUN;
          vld_d   = 1'b0;
          mis_d   = 1'b0;
          inst_d  = NOP;
        end else if (bus.i_hold) begin
          state_d = state_q;
        end else if (state_q == ST_MSTALL) begin
          vld_d  = 1'b0;
          mis_d  = 1'b0;
          inst_d = NOP;
        end else begin
          id_pc_d  = pc_q;
          nxt_pc_d = pc_q + 32'd4;
          vld_d    = 1'b1;
          if (pc_aligned(pc_q)) begin
            inst_d = bus.i_imem_rdata;
            mis_d  = 1'b0;
          end else begin
            inst_d  = NOP;
            mis_d   = 1'b1;
            state_d = ST_MSTALL;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    pc_q <= pc_d;
    if (i_rst) begin
      state_q  <= ST_RUN;
      inst_q   <= NOP;
      id_pc_q  <= '0;
      nxt_pc_q <= '0;
      vld_q    <= 1'b0;
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      id_pc_q  <= id_pc_d;
      nxt_pc_q <= nxt_pc_d;
      vld_q    <= vld_d;
      mis_q    <= mis_d;
      halted_q <= halted_d;
    end
  end

  assign bus.o_imem_raddr = pc_q;
  assign bus.o_imem_ren   = (state_q == ST_RUN) && pc_aligned(pc_q);
  assign bus.o_inst       = inst_q;
  assign bus.o_pc         = id_pc_q;
  assign bus.o_nxt_pc     = nxt_pc_q;
  assign bus.o_vld        = vld_q;
  assign bus.o_misalign   = mis_q;
  assign bus.o_halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_err;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two fixed words, every other address returns A000_0000|addr.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return 32'hA000_0000 | a;
    endcase
  endfunction

  assign bus.i_imem_rdata = imem(bus.o_imem_raddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic entry(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, ".vld"}, {31'd0, bus.o_vld}, 32'd1);
    chk({tag, ".pc"}, bus.o_pc, pc);
    chk({tag, ".nxt"}, bus.o_nxt_pc, pc + 32'd4);
    chk({tag, ".inst"}, bus.o_inst, inst);
    chk({tag, ".mis"}, {31'd0, bus.o_misalign}, 32'd0);
  endtask

  task automatic bubble(input string tag);
    chk({tag, ".vld"}, {31'd0, bus.o_vld}, 32'd0);
    chk({tag, ".inst"}, bus.o_inst, 32'h0000_0013);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = tgt;
    tick();
    bus.i_redirect    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_hold = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_halt = 1'b0;
    tick();
    tick();

    // reset state
    bubble("rst");
    chk("rst.pc", bus.o_pc, 32'h0);
    chk("rst.nxt", bus.o_nxt_pc, 32'h0);
    chk("rst.mis", {31'd0, bus.o_misalign}, 32'd0);
    chk("rst.halted", {31'd0, bus.o_halted}, 32'd0);
    chk("rst.raddr", bus.o_imem_raddr, 32'h0);
    chk("rst.ren", {31'd0, bus.o_imem_ren}, 32'd1);

    // sequential fetch
    rst = 1'b0;
    tick();
    entry("f0", 32'h0, 32'h0050_0093);
    tick();
    entry("f4", 32'h4, 32'h00A0_0113);
    tick();
    entry("f8", 32'h8, 32'hA000_0008);

    // hold three cycles at o_pc=8
    bus.i_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      entry("hold", 32'h8, 32'hA000_0008);
      chk("hold.raddr", bus.o_imem_raddr, 32'hC);
    end
    bus.i_hold = 1'b0;
    tick();
    entry("resume", 32'hC, 32'hA000_000C);

    // redirect overrides hold
    bus.i_hold = 1'b1;
    redirect_to(32'h40);
    bus.i_hold = 1'b0;
    bubble("rdh");
    chk("rdh.raddr", bus.o_imem_raddr, 32'h40);
    tick();
    entry("t40", 32'h40, 32'hA000_0040);

    // misaligned redirect target
    redirect_to(32'h42);
    bubble("m.flush");
    chk("m.flush.ren", {31'd0, bus.o_imem_ren}, 32'd0);
    tick();
    chk("m.vld", {31'd0, bus.o_vld}, 32'd1);
    chk("m.mis", {31'd0, bus.o_misalign}, 32'd1);
    chk("m.pc", bus.o_pc, 32'h42);
    chk("m.nxt", bus.o_nxt_pc, 32'h46);
    chk("m.inst", bus.o_inst, 32'h0000_0013);
    chk("m.ren", {31'd0, bus.o_imem_ren}, 32'd0);
    tick();
    bubble("m.bub");
    chk("m.bub.mis", {31'd0, bus.o_misalign}, 32'd0);
    chk("m.bub.raddr", bus.o_imem_raddr, 32'h42);
    chk("m.bub.ren", {31'd0, bus.o_imem_ren}, 32'd0);
    redirect_to(32'h80);
    bubble("m.out");
    chk("m.out.ren", {31'd0, bus.o_imem_ren}, 32'd1);
    tick();
    entry("t80", 32'h80, 32'hA000_0080);

    // halt at o_pc=0x10
    redirect_to(32'h10);
    tick();
    entry("t10", 32'h10, 32'hA000_0010);
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    bubble("halt");
    chk("halt.halted", {31'd0, bus.o_halted}, 32'd1);
    chk("halt.ren", {31'd0, bus.o_imem_ren}, 32'd0);
    chk("halt.raddr", bus.o_imem_raddr, 32'h14);
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      tick();
      bubble("halt.rd");
      chk("halt.rd.halted", {31'd0, bus.o_halted}, 32'd1);
      chk("halt.rd.raddr", bus.o_imem_raddr, 32'h14);
    end
    bus.i_redirect = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hrst.halted", {31'd0, bus.o_halted}, 32'd0);
    chk("hrst.raddr", bus.o_imem_raddr, 32'h0);
    tick();
    entry("hrst.f0", 32'h0, 32'h0050_0093);
    tick();
    entry("hrst.f4", 32'h4, 32'h00A0_0113);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    tick();
    entry("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("wrap.nxt0", bus.o_nxt_pc, 32'h0);
    tick();
    entry("wrap.f0", 32'h0, 32'h0050_0093);

    // reset mid-stall
    redirect_to(32'h42);
    tick();
    chk("ms.mis", {31'd0, bus.o_misalign}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bubble("ms.rst");
    chk("ms.rst.mis", {31'd0, bus.o_misalign}, 32'd0);
    chk("ms.rst.pc", bus.o_pc, 32'h0);
    chk("ms.rst.ren", {31'd0, bus.o_imem_ren}, 32'd1);
    tick();
    entry("ms.f0", 32'h0, 32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
